// File: rtl/bist_logic_param.sv
// bist_logic_param: y = isqrt(a + icbrt(b)) computed with bit-serial iterative
// units. A built-in self-test replays LFSR-generated operand pairs through the
// same datapath and compresses the results into a MISR signature.
module bist_logic_param #(
  parameter int          W         = 8,
  parameter int          NVEC      = 255,
  parameter int          SW        = 9,
  parameter logic [31:0] LFSR_POLY = 32'h0000_B400,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001,
  parameter logic [15:0] MISR_POLY = 16'h0110,
  parameter logic [15:0] GOLDEN    = 16'h0000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  input  logic          start_i,
  input  logic          test_button,
  output logic          busy_o,
  output logic [SW+3:0] y_o,
  output logic          pass_o,
  output logic          mode_o
);
  localparam int RW    = (W + 2) / 2;   // square-root result bits
  localparam int CW    = (W + 2) / 3;   // cube-root result bits, ceil(W/3)
  localparam int LW    = 2 * W;         // LFSR width: one a/b pair per state
  localparam int SUMW  = W + 1;         // a + icbrt(b) never exceeds W+1 bits
  localparam int CUBEW = 3 * CW;
  localparam int SQW   = 2 * RW;
  localparam int IW    = $clog2(RW + 1); // bit index covers both units (CW <= RW)
  localparam int NW    = (NVEC > 1) ? $clog2(NVEC) : 1;

  typedef enum logic [2:0] {
    IDLE, BINIT, LOAD, CBRT, SQRT, DONE, FOLD, BEND
  } state_t;

  state_t          state, state_nxt;
  logic            start_q, test_q;
  logic            start_trig, test_trig;
  logic            in_bist;
  logic            busy;
  logic [SW+3:0]   y;
  logic            pass, mode;
  logic [3:0]      run_cnt;
  logic [SW-1:0]   misr;
  logic [LW-1:0]   lfsr;
  logic [W-1:0]    op_a, op_b;
  logic [CW-1:0]   root_c, cbrt_nxt;
  logic [RW-1:0]   root_s;
  logic [SUMW-1:0] sum_r;
  logic [IW-1:0]   bit_idx;
  logic [NW-1:0]   vec_cnt;

  // Trial-and-keep cube root: set bit i, keep it only if the cube still fits.
  function automatic logic [CW-1:0] cbrt_step(input logic [CW-1:0] r,
                                              input logic [W-1:0]  x,
                                              input logic [IW-1:0] i);
    logic [CW-1:0]    t;
    logic [CUBEW-1:0] c;
    t = r | (CW'(1) << i);
    c = CUBEW'(t) * CUBEW'(t) * CUBEW'(t);
    return (c <= CUBEW'(x)) ? t : r;
  endfunction

  // Restoring square root step: tentatively set bit i, restore if the square overshoots.
  function automatic logic [RW-1:0] sqrt_step(input logic [RW-1:0]   r,
                                              input logic [SUMW-1:0] x,
                                              input logic [IW-1:0]   i);
    logic [RW-1:0]  t;
    logic [SQW-1:0] s;
    t = r | (RW'(1) << i);
    s = SQW'(t) * SQW'(t);
    return (s <= SQW'(x)) ? t : r;
  endfunction

  function automatic logic [SW-1:0] misr_step(input logic [SW-1:0] m,
                                              input logic [RW-1:0] r);
    logic [SW-1:0] s;
    s = {m[SW-2:0], 1'b0};
    if (m[SW-1]) s = s ^ MISR_POLY[SW-1:0];
    return s ^ SW'(r);
  endfunction

  function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] l);
    return l[0] ? ((l >> 1) ^ LFSR_POLY[LW-1:0]) : (l >> 1);
  endfunction

  assign start_trig = start_i & ~start_q;
  assign test_trig  = test_button & ~test_q;
  assign cbrt_nxt   = cbrt_step(root_c, op_b, bit_idx);

  assign busy_o = busy;
  assign y_o    = y;
  assign pass_o = pass;
  assign mode_o = mode;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; self-test request wins over a simultaneous user start.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (test_trig) state_nxt = BINIT;
               else if (start_trig) state_nxt = LOAD;
      BINIT:   state_nxt = LOAD;
      LOAD:    state_nxt = CBRT;
      CBRT:    if (bit_idx == '0) state_nxt = SQRT;
      SQRT:    if (bit_idx == '0) state_nxt = in_bist ? FOLD : DONE;
      DONE:    state_nxt = IDLE;
      FOLD:    state_nxt = (vec_cnt == NW'(NVEC - 1)) ? BEND : LOAD;
      BEND:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control, edge detectors, LFSR/MISR and visible result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_q <= 1'b0;
      test_q  <= 1'b0;
      in_bist <= 1'b0;
      busy    <= 1'b0;
      y       <= '0;
      pass    <= 1'b0;
      mode    <= 1'b0;
      run_cnt <= 4'd0;
      misr    <= '0;
      lfsr    <= LFSR_SEED[LW-1:0];
    end else begin
      start_q <= start_i;
      test_q  <= test_button;
      case (state)
        IDLE: begin
          if (test_trig) begin
            busy    <= 1'b1;
            in_bist <= 1'b1;
          end else if (start_trig) begin
            busy    <= 1'b1;
            in_bist <= 1'b0;
            pass    <= 1'b0;
          end
        end
        BINIT: begin
          lfsr <= LFSR_SEED[LW-1:0];
          misr <= '0;
        end
        LOAD: if (in_bist) lfsr <= lfsr_step(lfsr);
        DONE: begin
          y    <= (SW + 4)'(root_s);
          mode <= 1'b0;
          pass <= 1'b0;
          busy <= 1'b0;
        end
        FOLD: misr <= misr_step(misr, root_s);
        BEND: begin
          run_cnt <= run_cnt + 4'd1;
          y       <= {run_cnt + 4'd1, misr};
          pass    <= (misr == GOLDEN[SW-1:0]);
          mode    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Arithmetic datapath; every register here is initialised before it is used.
  always_ff @(posedge clk_i) begin
    case (state)
      IDLE: if (start_trig && !test_trig) begin
        op_a <= a_i;
        op_b <= b_i;
      end
      BINIT: vec_cnt <= '0;
      LOAD: begin
        if (in_bist) begin
          op_a <= lfsr[LW-1:W];
          op_b <= lfsr[W-1:0];
        end
        root_c  <= '0;
        bit_idx <= IW'(CW - 1);
      end
      CBRT: begin
        root_c <= cbrt_nxt;
        sum_r  <= SUMW'(op_a) + SUMW'(cbrt_nxt);
        if (bit_idx == '0) begin
          bit_idx <= IW'(RW - 1);
          root_s  <= '0;
        end else begin
          bit_idx <= bit_idx - IW'(1);
        end
      end
      SQRT: begin
        root_s  <= sqrt_step(root_s, sum_r, bit_idx);
        bit_idx <= bit_idx - IW'(1);
      end
      FOLD: vec_cnt <= vec_cnt + NW'(1);
      default: ;
    endcase
  end
endmodule

// File: doc/bist_logic_param.md
Name: bist_logic_param

Overview:
- Parametrised successor of the fixed 8-bit BIST datapath.
- Computes y = isqrt(a + icbrt(b)) on W-bit operands using multi-cycle iterative units.
- Built-in self-test mode: a 2W-bit LFSR drives NVEC pseudo-random vector pairs through the same datapath and compresses the results into an SW-bit MISR signature.
- Reports a 4-bit run counter, the signature, and a pass flag against a golden value. Sits between the operand/button front-end and the display/result register.

Parameters:
W, 8, operand width; even, 4..16.
NVEC, 255, vectors per BIST run; 1..2^(2W)-1.
SW, 9, MISR signature width; 4..16.
LFSR_POLY, 16'hB400, Galois LFSR taps; lower 2W bits used.
LFSR_SEED, 16'h0001, LFSR seed, nonzero; lower 2W bits used.
MISR_POLY, 9'h110, MISR feedback taps; lower SW bits used.
GOLDEN, 0, expected signature for pass_o.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
a_i  in  W  operand a
b_i  in  W  operand b
start_i  in  1  user-mode start, rising-edge triggered
test_button  in  1  BIST request, rising-edge triggered
busy_o  out  1  computation or BIST run in progress
y_o  out  4+SW  user mode: zero-extended result; BIST: {run_cnt[3:0], signature}
pass_o  out  1  last BIST signature == GOLDEN; cleared when a user op starts
mode_o  out  1  0 = last result is user, 1 = last result is BIST

Behaviour:
- Derived widths: RW = (W+2)/2 result bits; CW = ceil(W/3) cube-root bits.
- Reset: busy_o=0, y_o=0, pass_o=0, mode_o=0, run_cnt=0, MISR=0, LFSR=LFSR_SEED, FSM=IDLE, both edge detectors cleared.
- Edge detect: start_i and test_button are registered. A trigger is input high while the previous-cycle sample is low. Holding either input high gives exactly one trigger.
- Priority in IDLE: test_button trigger wins over a simultaneous start_i trigger. Triggers while busy_o=1 are dropped, not queued.

Core FSM: IDLE -> CBRT -> SQRT -> DONE.
- Accept cycle: a_i and b_i are latched and busy_o rises on the same edge.
- CBRT: digit-by-digit cube root, one result bit per cycle, exactly CW cycles, MSB first.
- SQRT: restoring square root of the (W+1)-bit sum a + icbrt(b), one bit per cycle, exactly RW cycles.
- DONE: 1 cycle. Latency is data-independent: 1 + CW + RW + 1 cycles from the trigger edge to busy_o falling. W=8 gives 10.
- User mode: in DONE, y_o = zero-extended result, mode_o=0, pass_o=0, busy_o falls. y_o holds until the next result or reset.

BIST FSM: BINIT -> (LOAD -> core -> FOLD) × NVEC -> BEND.
- BINIT: LFSR = LFSR_SEED, MISR = 0.
- LOAD: a = LFSR[2W-1:W], b = LFSR[W-1:0], then the LFSR advances one step.
- FOLD: MISR <= (MISR << 1 with feedback MISR_POLY when MSB set) XOR zero-extended result.
- BEND: run_cnt increments and wraps 15 -> 0. y_o = {run_cnt_new, MISR}, pass_o = (MISR == GOLDEN), mode_o=1, busy_o falls.
- y_o keeps its previous value for the whole run.
- The signature is deterministic: every run reseeds, so repeated runs differ only in run_cnt.
- Arithmetic: all intermediates are sized to avoid overflow. For W=8, the worst case is a=255, b=255: sum 261, result 16.
- Reset mid-operation: the next edge with rst_i=1 aborts any state and returns to reset values. run_cnt is also cleared.

Test Plan:
- W=8, user mode: (a,b) = (0,0)→0, (1,1)→1, (12,60)→3, (123,223)→11, (255,255)→16, (30,255)→6, (1,255)→2, (45,64)→7. y_o[12:5]=0 and mode_o=0 for each.
- Latency: start_i held high 1000 cycles → exactly one op; busy_o high for exactly 10 cycles; no retrigger until start_i falls and rises again.
- BIST: four test_button pulses, each after busy_o falls → y_o[12:9] = 1, 2, 3, 4 with an identical y_o[8:0]. With GOLDEN set to that signature, pass_o=1; with GOLDEN = signature^1, pass_o=0.
- Collisions: start_i and test_button rise on the same cycle → BIST runs. A start_i pulse during BIST is ignored and y_o is unchanged until BEND.
- Reset: rst_i asserted mid-BIST for 1 cycle → busy_o=0, y_o=0, run_cnt=0 next cycle. The next BIST reports run_cnt=1 and the same signature.
- Generalisation: W=12, NVEC=16 → user case a=4095, b=4095 gives isqrt(4095+15)=64. A BIST run completes with busy_o high for exactly 16×(LOAD + core + FOLD) + 2 cycles, cross-checked against a reference model.
